// File: rtl/spi_pkg.sv
// Shared types for the SPI transmit path (FIFO read side + shift engine).
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      HOLD
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: spi_sck toggling, leading/trailing strobes, edge counter.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH,
   parameter int CLK_DIV    = 4
) (
   input  logic SCLK,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   input  logic cpol,
   output logic sck,
   output logic lead,
   output logic trail,
   output logic first,
   output logic last
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EW = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [EW-1:0] EDGE_ONE = EW'(1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);

   logic [DW-1:0] div;
   logic [EW-1:0] edge_cnt;
   logic [EW-1:0] edge_nxt;
   logic          tick;

   assign tick     = run & (div == DIV_LAST);
   assign edge_nxt = edge_cnt + 1'b1;
   // odd-numbered edges are leading, even-numbered are trailing
   assign lead     = tick & edge_nxt[0];
   assign trail    = tick & ~edge_nxt[0];
   assign first    = (edge_nxt == EDGE_ONE);
   assign last     = (edge_nxt == EDGE_LAST);

   always_ff @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         div      <= '0;
         edge_cnt <= '0;
         sck      <= 1'b0;
      end else if (start) begin
         div      <= '0;
         edge_cnt <= '0;
         sck      <= cpol;
      end else if (run) begin
         if (tick) begin
            div      <= '0;
            edge_cnt <= edge_nxt;
            sck      <= ~sck;
         end else begin
            div <= div + 1'b1;
         end
      end else begin
         sck <= cpol;
      end
   end

endmodule

// File: rtl/spi_tx_engine.sv
// SPI master shift engine fed by the Tx FIFO read port.
// Optional SPI_LOOPBACK_EN adds an internal MOSI->RX loopback input.
module spi_tx_engine
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH,
   parameter int CLK_DIV    = 4,
   parameter int CS_HOLD    = 2
) (
   input  logic                  SCLK,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  cpol,
   input  logic                  cpha,
`ifdef SPI_LOOPBACK_EN
   input  logic                  loopback,
`endif
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  spi_sck,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_cs_n,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
);

   localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

   spi_state_t            state;
   spi_mode_t             mode;
   logic [DATA_WIDTH-1:0] tx_sr;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic [HW-1:0]         hold_cnt;
   logic                  lead;
   logic                  trail;
   logic                  first;
   logic                  last;
   logic                  sample;
   logic                  shift;
   logic                  din;

`ifdef SPI_LOOPBACK_EN
   logic lb;
   assign din = lb ? spi_mosi : spi_miso;
`else
   assign din = spi_miso;
`endif

   spi_clk_gen #(
      .DATA_WIDTH(DATA_WIDTH),
      .CLK_DIV   (CLK_DIV)
   ) u_clk_gen (
      .SCLK (SCLK),
      .rst_n(rst_n),
      .start(state == LOAD),
      .run  (state == SHIFT),
      .cpol (mode.cpol),
      .sck  (spi_sck),
      .lead (lead),
      .trail(trail),
      .first(first),
      .last (last)
   );

   // the rx_valid cycle is a forced idle gap between frames
   assign fifo_rd_en = (state == IDLE) & enable
                     & ~fifo_empty & ~rx_valid;
   assign busy     = (state != IDLE);
   assign spi_mosi = tx_sr[DATA_WIDTH-1];
   assign sample   = mode.cpha ? trail : lead;
   assign shift    = mode.cpha ? (lead & ~first)
                               : (trail & ~last);

   always_ff @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mode     <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         hold_cnt <= '0;
         spi_cs_n <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
`ifdef SPI_LOOPBACK_EN
         lb       <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fifo_rd_en) begin
                  mode.cpol <= cpol;
                  mode.cpha <= cpha;
`ifdef SPI_LOOPBACK_EN
                  lb        <= loopback;
`endif
                  state     <= FETCH;
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               tx_sr    <= fifo_data;
               rx_sr    <= '0;
               spi_cs_n <= 1'b0;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (shift)
                  tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
               if (sample)
                  rx_sr <= {rx_sr[DATA_WIDTH-2:0], din};
               if (trail & last) begin
                  hold_cnt <= '0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  spi_cs_n <= 1'b1;
                  rx_data  <= rx_sr;
                  rx_valid <= 1'b1;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
